// File: rtl/tl_ul_pkg.sv
// TileLink-UL buffer shared definitions.
// Opcode constants and channel bundle width helpers.
package tl_ul_pkg;

    localparam logic [2:0] OP_PUT_FULL        = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] OP_GET             = 3'd4;
    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    localparam int MAX_DEPTH = 8;

    // {opcode, param, size, source, address, mask, data}
    function automatic int a_width(input int addr_w,
                                   input int data_w,
                                   input int src_w);
        return 3 + 3 + 3 + src_w + addr_w + data_w / 8 + data_w;
    endfunction

    // {opcode, param, size, source, sink, denied, data, corrupt}
    function automatic int d_width(input int data_w,
                                   input int src_w);
        return 3 + 2 + 3 + src_w + 1 + 1 + data_w + 1;
    endfunction

endpackage

// File: rtl/tl_ul_queue.sv
// Valid/ready queue with optional flow-through and pipelined accept.
// Depth 0 degenerates to plain wiring.
module tl_ul_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int FLOW  = 0,
    parameter int PIPE  = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bits,
    output logic [3:0]       count
);

    localparam bit FLOW_EN = (FLOW != 0);
    localparam bit PIPE_EN = (PIPE != 0);

    generate
        if (DEPTH == 0) begin : g_wire
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
            assign out_bits  = in_bits;
            assign count     = 4'd0;

            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ reset_n;
        end else begin : g_fifo
            localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
            localparam int SLOTS = 1 << PW;
            localparam logic [3:0]    FULL_CNT = 4'(DEPTH);
            localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);

            logic [WIDTH-1:0] mem [SLOTS];
            logic [PW-1:0]    wptr;
            logic [PW-1:0]    rptr;
            logic [3:0]       cnt;
            logic             empty;
            logic             full;
            logic             in_fire;
            logic             out_fire;
            logic             bypass;
            logic             enq;
            logic             deq;

            // Wrap explicitly so non-power-of-two depths work.
            function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
                return (p == LAST) ? '0 : p + 1'b1;
            endfunction

            assign empty = (cnt == 4'd0);
            assign full  = (cnt == FULL_CNT);

            // Valid is held low while reset is asserted, even on bypass.
            assign out_valid = reset_n &&
                               (!empty || (FLOW_EN && in_valid));
            assign in_ready  = !full || (PIPE_EN && out_ready);
            assign out_bits  = (FLOW_EN && empty) ? in_bits : mem[rptr];

            assign in_fire  = in_valid && in_ready;
            assign out_fire = out_valid && out_ready;
            assign bypass   = FLOW_EN && empty && in_fire && out_fire;
            assign enq      = in_fire && !bypass;
            assign deq      = out_fire && !bypass;

            assign count = cnt;

            // Payload storage; contents need no reset.
            always_ff @(posedge clock) begin
                if (enq) begin
                    mem[wptr] <= in_bits;
                end
            end

            // Pointers and occupancy, cleared asynchronously.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    wptr <= '0;
                    rptr <= '0;
                    cnt  <= 4'd0;
                end else begin
                    if (enq) begin
                        wptr <= nxt(wptr);
                    end
                    if (deq) begin
                        rptr <= nxt(rptr);
                    end
                    if (enq && !deq) begin
                        cnt <= cnt + 4'd1;
                    end else if (deq && !enq) begin
                        cnt <= cnt - 4'd1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/tl_ul_buffer.sv
// TileLink-UL A/D channel buffer.
// Two independent queues, A downstream and D upstream.
module tl_ul_buffer
    import tl_ul_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = 2,
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int FLOW    = 0,
    parameter int PIPE    = 0,
    localparam int A_W = a_width(ADDR_W, DATA_W, SRC_W),
    localparam int D_W = d_width(DATA_W, SRC_W)
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           in_a_valid,
    output logic           in_a_ready,
    input  logic [A_W-1:0] in_a_bits,
    output logic           out_a_valid,
    input  logic           out_a_ready,
    output logic [A_W-1:0] out_a_bits,
    input  logic           out_d_valid,
    output logic           out_d_ready,
    input  logic [D_W-1:0] out_d_bits,
    output logic           in_d_valid,
    input  logic           in_d_ready,
    output logic [D_W-1:0] in_d_bits,
    output logic [3:0]     a_count,
    output logic [3:0]     d_count
);

    tl_ul_queue #(
        .WIDTH (A_W),
        .DEPTH (A_DEPTH),
        .FLOW  (FLOW),
        .PIPE  (PIPE)
    ) u_a_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_a_valid),
        .in_ready  (in_a_ready),
        .in_bits   (in_a_bits),
        .out_valid (out_a_valid),
        .out_ready (out_a_ready),
        .out_bits  (out_a_bits),
        .count     (a_count)
    );

    tl_ul_queue #(
        .WIDTH (D_W),
        .DEPTH (D_DEPTH),
        .FLOW  (FLOW),
        .PIPE  (PIPE)
    ) u_d_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (out_d_valid),
        .in_ready  (out_d_ready),
        .in_bits   (out_d_bits),
        .out_valid (in_d_valid),
        .out_ready (in_d_ready),
        .out_bits  (in_d_bits),
        .count     (d_count)
    );

endmodule

// File: doc/tl_ul_buffer.md
TL_UL_BUFFER -- requirements
Module: tl_ul_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, A-channel address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; mask width is DATA_W/8.
REQ-003 SHALL have parameter SRC_W, default 2, source-ID width.
REQ-004 SHALL have parameter A_DEPTH, default 2, A-queue entries; legal range 0..8.
REQ-005 SHALL have parameter D_DEPTH, default 2, D-queue entries; legal range 0..8.
REQ-006 SHALL have parameter FLOW, default 0; 1 lets an empty queue pass input to output in the same cycle.
REQ-007 SHALL have parameter PIPE, default 0; 1 lets a full queue accept input in a cycle it dequeues.
REQ-008 SHALL have port clock, input, 1, the only clock; all flops rise on it.
REQ-009 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port in_a_valid / in_a_ready, input / output, 1 / 1, upstream A handshake.
REQ-011 SHALL have port in_a_bits, input, A_W, packed {opcode[2:0], param[2:0], size[2:0], source, address, mask, data}.
REQ-012 SHALL have port out_a_valid / out_a_ready / out_a_bits, output / input / output, 1 / 1 / A_W, downstream A.
REQ-013 SHALL have port out_d_valid / out_d_ready / out_d_bits, input / output / input, 1 / 1 / D_W, downstream D; packed {opcode[2:0], param[1:0], size[2:0], source, sink[0], denied, data, corrupt}.
REQ-014 SHALL have port in_d_valid / in_d_ready / in_d_bits, output / input / output, 1 / 1 / D_W, upstream D.
REQ-015 SHALL have port a_count / d_count, output, 4 / 4, current queue occupancy.

Function
REQ-016 A and D paths SHALL be independent queues of depth A_DEPTH and D_DEPTH; payload SHALL be carried bit-exact, in order.
REQ-017 Depth 0 SHALL be pure wiring: valid, ready and bits pass combinationally; count outputs tie to 0.
REQ-018 Enqueue SHALL occur when in-side valid and ready are both 1 on a rising clock edge; dequeue when out-side valid and ready are both 1.
REQ-019 Out valid SHALL equal (count != 0), or additionally in-valid when FLOW=1 and count=0.
REQ-020 In ready SHALL equal (count != DEPTH), or additionally out-ready when PIPE=1 and count=DEPTH.
REQ-021 With FLOW=1, count=0, and in/out both firing, the beat SHALL bypass storage; count stays 0.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged; pointers both advance.
REQ-023 Read/write pointers SHALL wrap from DEPTH-1 to 0, including non-power-of-two depths.
REQ-024 Minimum latency SHALL be 1 cycle (in fire -> out valid next cycle) with FLOW=0, 0 cycles with FLOW=1.
REQ-025 Out bits SHALL be stable while out valid=1 and out ready=0.
REQ-026 Full throughput (one beat per cycle sustained) SHALL be achieved for DEPTH>=2 or PIPE=1.

Reset
REQ-027 reset_n low SHALL asynchronously clear pointers and counts; out_a_valid, in_d_valid, a_count, d_count = 0 during reset.
REQ-028 in_a_ready and out_d_ready SHALL be 1 when out of reset with DEPTH>0; storage array need not be reset.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered beats; no beat emitted after deassertion until a new enqueue.
REQ-030 Deassertion SHALL be applied synchronously in the instantiating reset tree; the block shall not add a synchronizer.

Structure
REQ-031 A shared package tl_ul_pkg SHALL hold opcode constants (Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1) and A_W/D_W width functions.
REQ-032 One sub-module tl_ul_queue (parametrised WIDTH, DEPTH, FLOW, PIPE) SHALL be instantiated once per channel.

Verification
REQ-033 Defaults, push 2 A beats (address 0x1000, 0x1004) with out_a_ready=0 -> a_count=2, in_a_ready=0; release ready -> beats out in order on consecutive cycles.
REQ-034 FLOW=1, empty, in_a_valid with out_a_ready=1 -> out_a_valid and bits same cycle; a_count stays 0.
REQ-035 PIPE=1, DEPTH=1, full, out_a_ready=1 and new beat -> in_a_ready=1, beat accepted, a_count stays 1.
REQ-036 DEPTH=3, 10 random D beats with random stalls -> sequence matches scoreboard; pointer wrap exercised.
REQ-037 Assert reset_n low with d_count=2 -> in_d_valid=0 and d_count=0 immediately; after release, no stale beat appears.
REQ-038 A_DEPTH=0 -> out_a_* equal in_a_* combinationally for 100 random cycles.
